// File: rtl/missile_scheduler.sv
// Invader missile scheduler: three missile slots advanced/retired once per frame, launches from the
// bottom-most alive invader of a chosen column. Define MISSILE_AIM_EN to aim the column at i_player_x.
module missile_scheduler #(
  parameter int INVADERS_H    = 11,
  parameter int INVADERS_V    = 5,
  parameter int OFFSET_H      = 40,
  parameter int OFFSET_V      = 32,
  parameter int INV_W         = 24,
  parameter int INV_H         = 16,
  parameter int MISSILE_SPEED = 2,
  parameter int SCREEN_BOTTOM = 464,
  parameter int FIRE_PERIOD   = 40,
  parameter int PARK          = 1023
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_frame,
  input  logic                             i_enable,
  input  logic [INVADERS_H*INVADERS_V-1:0] i_invaders,
  input  logic [9:0]                       i_invaders_x,
  input  logic [9:0]                       i_invaders_y,
  input  logic [1:0]                       i_player_collision,
`ifdef MISSILE_AIM_EN
  input  logic [9:0]                       i_player_x,
`endif
  output logic [9:0]                       o_m1_x,
  output logic [9:0]                       o_m1_y,
  output logic [9:0]                       o_m2_x,
  output logic [9:0]                       o_m2_y,
  output logic [9:0]                       o_m3_x,
  output logic [9:0]                       o_m3_y,
  output logic [2:0]                       o_m_active,
  output logic                             o_fire
);

  localparam int NBITS   = INVADERS_H * INVADERS_V;
  localparam int COL_W   = (INVADERS_H > 1) ? $clog2(INVADERS_H) : 1;
  localparam int ROW_W   = (INVADERS_V > 1) ? $clog2(INVADERS_V) : 1;
  localparam int TRY_W   = $clog2(INVADERS_H + 1);
  localparam int IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int TIMER_W = $clog2(FIRE_PERIOD + 1);

  localparam logic [9:0]         PARK_V       = 10'(PARK);
  localparam logic [9:0]         SPEED_V      = 10'(MISSILE_SPEED);
  localparam logic [9:0]         BOTTOM_V     = 10'(SCREEN_BOTTOM);
  localparam logic [9:0]         HALF_W_V     = 10'(INV_W / 2);
  localparam logic [9:0]         INV_H_V      = 10'(INV_H);
  localparam logic [COL_W-1:0]   LAST_COL     = COL_W'(INVADERS_H - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW     = ROW_W'(INVADERS_V - 1);
  localparam logic [TRY_W-1:0]   ALL_COLS     = TRY_W'(INVADERS_H);
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(FIRE_PERIOD);
  localparam logic [7:0]         LFSR_SEED    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_CHECK,
    S_SCAN,
    S_LAUNCH
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_frame_pending;
  logic [TIMER_W-1:0] r_timer;
  logic [7:0]         r_lfsr;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [TRY_W-1:0]   r_cols_tried;
  logic [2:0][9:0]    r_mx;
  logic [2:0][9:0]    r_my;
  logic [2:0]         r_active;
  logic               r_fire;

  logic               w_pending_next;
  logic [TIMER_W-1:0] w_timer_next;
  logic [7:0]         w_lfsr_next;
  logic [COL_W-1:0]   w_col_next;
  logic [ROW_W-1:0]   w_row_next;
  logic [TRY_W-1:0]   w_tried_next;
  logic [2:0][9:0]    w_mx_next;
  logic [2:0][9:0]    w_my_next;
  logic [2:0]         w_active_next;
  logic               w_fire_next;

  logic [2:0][9:0]    w_my_sum;
  logic [COL_W-1:0]   w_start_col;
  logic [IDX_W-1:0]   w_bit_idx;
  logic [TRY_W-1:0]   w_tried_inc;
  logic [9:0]         w_launch_x;
  logic [9:0]         w_launch_y;
  logic               w_free_valid;
  logic [1:0]         w_free_idx;

`ifdef MISSILE_AIM_EN
  // Column under the player, clamped to the formation; LFSR keeps stepping but is not consulted.
  logic [9:0] w_aim_dx;
  logic [9:0] w_aim_q;
  assign w_aim_dx    = i_player_x - i_invaders_x;
  assign w_aim_q     = w_aim_dx / 10'(OFFSET_H);
  assign w_start_col = (i_player_x < i_invaders_x)       ? '0 :
                       (w_aim_q >= 10'(INVADERS_H - 1)) ? LAST_COL : COL_W'(w_aim_q);
`else
  assign w_start_col = COL_W'(r_lfsr % 8'(INVADERS_H));
`endif

  assign w_bit_idx   = IDX_W'(r_row) * IDX_W'(INVADERS_H) + IDX_W'(r_col);
  assign w_tried_inc = r_cols_tried + TRY_W'(1);
  assign w_launch_x  = i_invaders_x + 10'(32'(r_col) * OFFSET_H) + HALF_W_V;
  assign w_launch_y  = i_invaders_y + 10'(32'(r_row) * OFFSET_V) + INV_H_V;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_my_sum[k] = r_my[k] + SPEED_V;
    end
  end

  // Descending scan so the lowest-index free slot is the one that sticks.
  always_comb begin
    w_free_valid = 1'b0;
    w_free_idx   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (!r_active[k]) begin
        w_free_valid = 1'b1;
        w_free_idx   = 2'(k);
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_frame_pending;
    w_timer_next   = r_timer;
    w_lfsr_next    = r_lfsr;
    w_col_next     = r_col;
    w_row_next     = r_row;
    w_tried_next   = r_cols_tried;
    w_mx_next      = r_mx;
    w_my_next      = r_my;
    w_active_next  = r_active;
    w_fire_next    = 1'b0;

    if (!i_enable) begin
      w_state_next   = S_IDLE;
      w_pending_next = 1'b0;
      w_timer_next   = TIMER_RELOAD;
      w_active_next  = '0;
      for (int k = 0; k < 3; k++) begin
        w_mx_next[k] = PARK_V;
        w_my_next[k] = PARK_V;
      end
    end else begin
      if (r_state != S_IDLE && i_frame) begin
        w_pending_next = 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_frame || r_frame_pending) begin
            w_state_next   = S_MOVE;
            w_pending_next = i_frame && r_frame_pending;
          end
        end

        S_MOVE: begin
          for (int k = 0; k < 3; k++) begin
            if (r_active[k]) begin
              if (w_my_sum[k] >= BOTTOM_V) begin
                w_active_next[k] = 1'b0;
                w_mx_next[k]     = PARK_V;
                w_my_next[k]     = PARK_V;
              end else begin
                w_my_next[k] = w_my_sum[k];
              end
            end
          end
          if (r_timer != '0) begin
            w_timer_next = r_timer - TIMER_W'(1);
          end
          w_lfsr_next  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
          w_state_next = S_CHECK;
        end

        // An expired timer with every slot busy stays at zero until a slot frees.
        S_CHECK: begin
          if (r_timer == '0 && !(&r_active)) begin
            w_state_next = S_SCAN;
            w_col_next   = w_start_col;
            w_row_next   = LAST_ROW;
            w_tried_next = '0;
          end else begin
            w_state_next = S_IDLE;
          end
        end

        S_SCAN: begin
          if (i_invaders[w_bit_idx]) begin
            w_state_next = S_LAUNCH;
          end else if (r_row != '0) begin
            w_row_next = r_row - ROW_W'(1);
          end else if (w_tried_inc == ALL_COLS) begin
            w_state_next = S_IDLE;
            w_timer_next = TIMER_RELOAD;
          end else begin
            w_col_next   = (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
            w_row_next   = LAST_ROW;
            w_tried_next = w_tried_inc;
          end
        end

        S_LAUNCH: begin
          if (w_free_valid) begin
            w_mx_next[w_free_idx]     = w_launch_x;
            w_my_next[w_free_idx]     = w_launch_y;
            w_active_next[w_free_idx] = 1'b1;
            w_fire_next               = 1'b1;
          end
          w_timer_next = TIMER_RELOAD;
          w_state_next = S_IDLE;
        end

        default: w_state_next = S_IDLE;
      endcase

      // Applied last so a player hit overrides the same-cycle advance of that slot.
      for (int k = 0; k < 3; k++) begin
        if (i_player_collision == 2'(k + 1) && r_active[k]) begin
          w_active_next[k] = 1'b0;
          w_mx_next[k]     = PARK_V;
          w_my_next[k]     = PARK_V;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_pending <= 1'b0;
      r_timer         <= TIMER_RELOAD;
      r_lfsr          <= LFSR_SEED;
      r_col           <= '0;
      r_row           <= '0;
      r_cols_tried    <= '0;
      r_mx            <= {3{PARK_V}};
      r_my            <= {3{PARK_V}};
      r_active        <= '0;
      r_fire          <= 1'b0;
    end else begin
      r_frame_pending <= w_pending_next;
      r_timer         <= w_timer_next;
      r_lfsr          <= w_lfsr_next;
      r_col           <= w_col_next;
      r_row           <= w_row_next;
      r_cols_tried    <= w_tried_next;
      r_mx            <= w_mx_next;
      r_my            <= w_my_next;
      r_active        <= w_active_next;
      r_fire          <= w_fire_next;
    end
  end

  assign o_m1_x     = r_mx[0];
  assign o_m1_y     = r_my[0];
  assign o_m2_x     = r_mx[1];
  assign o_m2_y     = r_my[1];
  assign o_m3_x     = r_mx[2];
  assign o_m3_y     = r_my[2];
  assign o_m_active = r_active;
  assign o_fire     = r_fire;

endmodule

// File: tb/tb_missile_scheduler.sv
// Testbench for missile_scheduler: launch table, hand-written multi-frame sequences and a randomized
// run checked frame by frame against a behavioural model of the scheduling rules.
module tb_missile_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame;
  logic        enable;
  logic [54:0] invaders;
  logic [9:0]  invX;
  logic [9:0]  invY;
  logic [1:0]  collision;
  logic [9:0]  m1x, m1y, m2x, m2y, m3x, m3y;
  logic [2:0]  mActive;
  logic        fire;

  logic [9:0]  outX [3];
  logic [9:0]  outY [3];

  int errors = 0;
  int checks = 0;
  int fireCount = 0;

  logic [9:0] mdlX [3];
  logic [9:0] mdlY [3];
  logic [2:0] mdlAct;
  int         mdlTimer;
  logic [7:0] mdlLfsr;

  typedef struct {
    logic [54:0] inv;
    logic [9:0]  ox;
    logic [9:0]  oy;
    logic [9:0]  ex;
    logic [9:0]  ey;
  } vec_t;

  missile_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .i_frame            (frame),
    .i_enable           (enable),
    .i_invaders         (invaders),
    .i_invaders_x       (invX),
    .i_invaders_y       (invY),
    .i_player_collision (collision),
    .o_m1_x             (m1x),
    .o_m1_y             (m1y),
    .o_m2_x             (m2x),
    .o_m2_y             (m2y),
    .o_m3_x             (m3x),
    .o_m3_y             (m3y),
    .o_m_active         (mActive),
    .o_fire             (fire)
  );

  always #5 clk = ~clk;

  assign outX[0] = m1x;
  assign outY[0] = m1y;
  assign outX[1] = m2x;
  assign outY[1] = m2y;
  assign outX[2] = m3x;
  assign outY[2] = m3y;

  always @(negedge clk) begin
    if (fire) fireCount++;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkSlot(input string name, input int k, input logic [9:0] ex, input logic [9:0] ey);
    checkOutput($sformatf("%s slot%0d x", name, k + 1), outX[k], ex);
    checkOutput($sformatf("%s slot%0d y", name, k + 1), outY[k], ey);
  endtask

  // One frame pulse followed by enough idle cycles for the worst-case scan and launch.
  task automatic applyStimulus(input int nFrames);
    for (int n = 0; n < nFrames; n++) begin
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
      repeat (64) @(negedge clk);
    end
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    frame     = 1'b0;
    enable    = 1'b1;
    collision = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic modelReset();
    mdlAct   = 3'b000;
    mdlTimer = 40;
    mdlLfsr  = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      mdlX[k] = 10'd1023;
      mdlY[k] = 10'd1023;
    end
  endtask

  task automatic modelRetire(input int k);
    mdlAct[k] = 1'b0;
    mdlX[k]   = 10'd1023;
    mdlY[k]   = 10'd1023;
  endtask

  // Whole-frame effect: advance, retire, timer, then pick the firing invader column by column.
  task automatic modelFrame(input logic [54:0] inv, input logic [9:0] ox, input logic [9:0] oy,
                            output int fired);
    int start, fc, fr, slot;
    bit found;
    fired = 0;
    found = 1'b0;
    fc    = 0;
    fr    = 0;
    slot  = 0;
    for (int k = 0; k < 3; k++) begin
      if (mdlAct[k]) begin
        mdlY[k] = mdlY[k] + 10'd2;
        if (mdlY[k] >= 10'd464) modelRetire(k);
      end
    end
    if (mdlTimer > 0) mdlTimer--;
    mdlLfsr = {mdlLfsr[6:0], mdlLfsr[7] ^ mdlLfsr[5] ^ mdlLfsr[4] ^ mdlLfsr[3]};
    if (mdlTimer == 0 && mdlAct != 3'b111) begin
      start = int'(mdlLfsr) % 11;
      for (int t = 0; t < 11; t++) begin
        for (int r = 4; r >= 0; r--) begin
          if (!found && inv[r * 11 + (start + t) % 11]) begin
            found = 1'b1;
            fc    = (start + t) % 11;
            fr    = r;
          end
        end
      end
      mdlTimer = 40;
      if (found) begin
        for (int k = 2; k >= 0; k--) begin
          if (!mdlAct[k]) slot = k;
        end
        mdlX[slot]   = 10'(int'(ox) + fc * 40 + 12);
        mdlY[slot]   = 10'(int'(oy) + fr * 32 + 16);
        mdlAct[slot] = 1'b1;
        fired        = 1;
      end
    end
  endtask

  initial begin
    vec_t        vecs [5];
    int          base;
    int          fired;
    int          k;
    logic [54:0] rinv;

    vecs[0] = '{55'd1 << 54, 10'd100,  10'd50,  10'd512, 10'd194};
    vecs[1] = '{55'd1,       10'd0,    10'd0,   10'd12,  10'd16};
    vecs[2] = '{55'd1 << 22, 10'd10,   10'd20,  10'd22,  10'd100};
    vecs[3] = '{(55'd1 << 5) | (55'd1 << 38), 10'd200, 10'd100, 10'd412, 10'd212};
    vecs[4] = '{55'd1 << 54, 10'd1000, 10'd1000, 10'd388, 10'd120};

    invaders = '0;
    invX     = 10'd0;
    invY     = 10'd0;
    rst       = 1'b1;
    frame     = 1'b0;
    enable    = 1'b1;
    collision = 2'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset active", mActive, 0);
    checkOutput("reset fire", fire, 0);
    for (int s = 0; s < 3; s++) checkSlot("reset", s, 10'd1023, 10'd1023);

    // Single-launch table: one alive column, so the result does not depend on the start column.
    for (int v = 0; v < 5; v++) begin
      resetDut();
      invaders = vecs[v].inv;
      invX     = vecs[v].ox;
      invY     = vecs[v].oy;
      base     = fireCount;
      applyStimulus(39);
      checkOutput($sformatf("tbl%0d early fire", v), fireCount - base, 0);
      applyStimulus(1);
      checkOutput($sformatf("tbl%0d fire", v), fireCount - base, 1);
      checkOutput($sformatf("tbl%0d active", v), mActive, 1);
      checkSlot($sformatf("tbl%0d", v), 0, vecs[v].ex, vecs[v].ey);
      checkSlot($sformatf("tbl%0d", v), 1, 10'd1023, 10'd1023);
    end

    // Flight, saturation with all slots busy, player hit and refill, bottom retire.
    resetDut();
    invaders = 55'd1 << 54;
    invX     = 10'd100;
    invY     = 10'd0;
    applyStimulus(40);
    checkSlot("seqA f40", 0, 10'd512, 10'd144);
    applyStimulus(1);
    checkSlot("seqA f41", 0, 10'd512, 10'd146);
    applyStimulus(1);
    checkSlot("seqA f42", 0, 10'd512, 10'd148);
    applyStimulus(38);
    checkOutput("seqA f80 active", mActive, 3'b011);
    checkSlot("seqA f80", 0, 10'd512, 10'd224);
    checkSlot("seqA f80", 1, 10'd512, 10'd144);
    applyStimulus(40);
    checkOutput("seqA f120 active", mActive, 3'b111);
    base = fireCount;
    applyStimulus(41);
    checkOutput("seqA full no fire", fireCount - base, 0);
    checkOutput("seqA full active", mActive, 3'b111);
    collision = 2'd2;
    @(negedge clk);
    collision = 2'd0;
    checkOutput("seqA hit active", mActive, 3'b101);
    checkSlot("seqA hit", 1, 10'd1023, 10'd1023);
    @(negedge clk);
    applyStimulus(1);
    checkOutput("seqA refill fire", fireCount - base, 1);
    checkOutput("seqA refill active", mActive, 3'b111);
    checkSlot("seqA refill", 1, 10'd512, 10'd144);
    applyStimulus(37);
    checkSlot("seqA f199", 0, 10'd512, 10'd462);
    applyStimulus(1);
    checkOutput("seqA f200 active", mActive, 3'b110);
    checkSlot("seqA f200", 0, 10'd1023, 10'd1023);

    // Empty formation scan, timer reload, then asynchronous reset in the middle of a scan.
    resetDut();
    invaders = '0;
    invX     = 10'd100;
    invY     = 10'd50;
    base     = fireCount;
    applyStimulus(40);
    checkOutput("seqB empty fire", fireCount - base, 0);
    checkOutput("seqB empty active", mActive, 0);
    invaders = 55'd1 << 54;
    applyStimulus(39);
    checkOutput("seqB reload early", fireCount - base, 0);
    applyStimulus(1);
    checkOutput("seqB reload fire", fireCount - base, 1);
    checkSlot("seqB launch", 0, 10'd512, 10'd194);
    invaders = '0;
    applyStimulus(39);
    checkOutput("seqB pre-reset active", mActive, 3'b001);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("seqB async active", mActive, 0);
    checkOutput("seqB async fire", fire, 0);
    checkSlot("seqB async", 0, 10'd1023, 10'd1023);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Frame arriving mid-scan is held and replayed exactly once; enable low clears everything.
    resetDut();
    invaders = 55'd1;
    invX     = 10'd100;
    invY     = 10'd50;
    base     = fireCount;
    applyStimulus(39);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    repeat (2) @(negedge clk);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    repeat (70) @(negedge clk);
    checkOutput("seqC fire", fireCount - base, 1);
    checkSlot("seqC pending", 0, 10'd112, 10'd68);
    applyStimulus(1);
    checkSlot("seqC next", 0, 10'd112, 10'd70);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("seqC disable active", mActive, 0);
    checkSlot("seqC disable", 0, 10'd1023, 10'd1023);
    enable = 1'b1;
    @(negedge clk);

    // Randomized frames against the model.
    resetDut();
    modelReset();
    invaders = '0;
    for (int it = 0; it < 360; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int b = 0; b < 55; b++) rinv[b] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) == 0) rinv = '0;
        invaders = rinv;
        invX     = 10'($urandom_range(0, 1023));
        invY     = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 39) == 0) begin
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        modelReset();
        mdlLfsr = dut.r_lfsr;
        checkOutput("rnd disable active", mActive, 0);
        @(negedge clk);
      end
      base = fireCount;
      applyStimulus(1);
      modelFrame(invaders, invX, invY, fired);
      checkOutput($sformatf("rnd%0d fire", it), fireCount - base, fired);
      checkOutput($sformatf("rnd%0d active", it), mActive, mdlAct);
      for (int s = 0; s < 3; s++) checkSlot($sformatf("rnd%0d", it), s, mdlX[s], mdlY[s]);
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 3);
        collision = 2'(k);
        @(negedge clk);
        collision = 2'd0;
        @(negedge clk);
        if (k != 0 && mdlAct[k - 1]) modelRetire(k - 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
